// File: rtl/ipmult_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : ipmult_ctrl_if
//  Description : Operand, randomness and result handshakes between the masked
//                round controller (master) and the IPMult sequencer (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface ipmult_ctrl_if #(
    parameter int V = 8
);
    // Operand set
    logic               in_valid;
    logic               in_ready;
    logic [V*8-1:0]     in_r;
    logic [V*8-1:0]     in_q;
    logic [V*V*8-1:0]   in_l_hat;

    // Byte-wide randomness stream
    logic               rnd_valid;
    logic               rnd_ready;
    logic [7:0]         rnd_data;

    // Product result
    logic               out_valid;
    logic               out_ready;
    logic [V*8-1:0]     out_t;
    logic               out_err;

    modport master (
        output in_valid, in_r, in_q, in_l_hat, rnd_valid, rnd_data, out_ready,
        input  in_ready, rnd_ready, out_valid, out_t, out_err
    );

    modport slave (
        input  in_valid, in_r, in_q, in_l_hat, rnd_valid, rnd_data, out_ready,
        output in_ready, rnd_ready, out_valid, out_t, out_err
    );
endinterface
`default_nettype wire

// File: rtl/ipmult_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ipmult / ipmult_ctrl
//  Description : ipmult     - combinational IPM multiplier datapath over
//                             GF(2^8) (AES polynomial 0x11B).
//                ipmult_ctrl - sequencer: captures one operand set, gathers
//                             V*V-1 fresh random bytes, lets the datapath
//                             settle and presents the registered product T.
//  Revision    : 1.0 - initial release
// ============================================================================
//
//  Datapath contract (ipmult):
//    P(i,j) = L_hat(i,j) * R_i * Q_j
//    U(k)   = P(k) ^ rnd_k            for k = i*V+j < V*V-1
//    U(V*V-1) = P(V*V-1) ^ (xor of all rnd_k)   -> xor of U equals xor of P
//    T_i    = xor_j U(i,j)            for i < V-1
//    T_{V-1} solves  xor_j L_hat(V-1,j)*T_j = xor of P,
//    i.e. it is scaled by 1/L_hat(V-1,V-1); a zero there has no inverse,
//    which is why the sequencer short-circuits that case with out_err.
//    With L_hat(i,j) = L_i*L_j and L_{V-1} = 1, the row L_hat(V-1,*) is
//    the decoding vector L and T decodes to decode(R)*decode(Q).
module ipmult #(
    parameter int V = 8
) (
    input  wire logic [V*8-1:0]     r,
    input  wire logic [V*8-1:0]     q,
    input  wire logic [V*V*8-1:0]   l_hat,
    input  wire logic [V*V*8-2:0]   rnd,
    output logic      [V*8-1:0]     t
);
    localparam int N = V * V;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1B) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    // a^254 = a^-1 for a != 0 (and 0 for a == 0)
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    logic [7:0] u [N];
    logic [7:0] rnd_sum;
    logic [7:0] total;
    logic [7:0] row;
    logic [7:0] fix;

    // Pad bits above the last random byte carry nothing
    logic unused_pad;
    assign unused_pad = ^rnd[N*8-2:(N-1)*8];

    // Products, zero-sum refresh, row compression and last-share solve
    always_comb begin
        rnd_sum = 8'h00;
        total   = 8'h00;
        row     = 8'h00;
        fix     = 8'h00;
        t       = '0;
        for (int k = 0; k < N; k++) u[k] = 8'h00;

        for (int i = 0; i < V; i++) begin
            for (int j = 0; j < V; j++) begin
                u[i*V+j] = gf_mul(gf_mul(l_hat[8*(i*V+j) +: 8], r[8*i +: 8]), q[8*j +: 8]);
                total    = total ^ u[i*V+j];
            end
        end

        for (int k = 0; k < N-1; k++) begin
            u[k]    = u[k] ^ rnd[8*k +: 8];
            rnd_sum = rnd_sum ^ rnd[8*k +: 8];
        end
        u[N-1] = u[N-1] ^ rnd_sum;

        fix = total;
        for (int i = 0; i < V-1; i++) begin
            row = 8'h00;
            for (int j = 0; j < V; j++) row = row ^ u[i*V+j];
            t[8*i +: 8] = row;
            fix = fix ^ gf_mul(l_hat[8*((V-1)*V+i) +: 8], row);
        end
        t[8*(V-1) +: 8] = gf_mul(fix, gf_inv(l_hat[8*(N-1) +: 8]));
    end
endmodule

module ipmult_ctrl #(
    parameter int V      = 8,
    parameter int SETTLE = 1
) (
    input  wire logic       clk,
    input  wire logic       rst,
    ipmult_ctrl_if.slave    bus,
    output logic            busy
);
    localparam int N  = V * V;
    localparam int RW = $clog2(N);
    localparam int SW = $clog2(SETTLE + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RAND    = 2'd1,
        COMPUTE = 2'd2,
        OUT     = 2'd3
    } state_t;

    state_t                 state;
    logic [RW-1:0]          rcnt;
    logic [SW-1:0]          scnt;
    logic [V*8-1:0]         opnd_r;
    logic [V*8-1:0]         opnd_q;
    logic [N*8-1:0]         opnd_l;
    logic [(N-1)*8-1:0]     rnd_reg;
    logic [N*8-2:0]         rand_bus;
    logic [V*8-1:0]         dp_t;

    // Only V*V-1 bytes are collected; the 7 bits above them stay zero
    assign rand_bus = {7'b0, rnd_reg};

    ipmult #(
        .V      (V)
    ) u_ipmult (
        .r      (opnd_r),
        .q      (opnd_q),
        .l_hat  (opnd_l),
        .rnd    (rand_bus),
        .t      (dp_t)
    );

    // Sequencer FSM; every handshake output is a register so in_ready and
    // rnd_ready depend on state alone
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            rcnt          <= '0;
            scnt          <= '0;
            opnd_r        <= '0;
            opnd_q        <= '0;
            opnd_l        <= '0;
            rnd_reg       <= '0;
            bus.in_ready  <= 1'b1;
            bus.rnd_ready <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_err   <= 1'b0;
            bus.out_t     <= '0;
            busy          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && bus.in_ready) begin
                        opnd_r       <= bus.in_r;
                        opnd_q       <= bus.in_q;
                        opnd_l       <= bus.in_l_hat;
                        bus.in_ready <= 1'b0;
                        busy         <= 1'b1;
                        if (bus.in_l_hat[8*(N-1) +: 8] == 8'h00) begin
                            // Singular last L_hat byte: report without touching randomness
                            state         <= OUT;
                            bus.out_t     <= '0;
                            bus.out_err   <= 1'b1;
                            bus.out_valid <= 1'b1;
                        end else begin
                            state         <= RAND;
                            rcnt          <= '0;
                            bus.rnd_ready <= 1'b1;
                        end
                    end
                end
                RAND: begin
                    if (bus.rnd_valid) begin
                        rnd_reg[8*rcnt +: 8] <= bus.rnd_data;
                        rcnt                 <= rcnt + 1'b1;
                        if (rcnt == RW'(N-2)) begin
                            state         <= COMPUTE;
                            scnt          <= '0;
                            bus.rnd_ready <= 1'b0;
                        end
                    end
                end
                COMPUTE: begin
                    if (scnt == SW'(SETTLE-1)) begin
                        state         <= OUT;
                        bus.out_t     <= dp_t;
                        bus.out_err   <= 1'b0;
                        bus.out_valid <= 1'b1;
                    end else begin
                        scnt <= scnt + 1'b1;
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        // Drop the randomness with the result so it is never reused
                        state         <= IDLE;
                        rnd_reg       <= '0;
                        bus.out_valid <= 1'b0;
                        bus.out_err   <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        busy          <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_ipmult_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ipmult_ctrl
//  Description : Self-checking bench for ipmult_ctrl (V=8, SETTLE=1) against
//                a GF(2^8) reference model of the IPM product.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ipmult_ctrl;
    localparam int V      = 8;
    localparam int SETTLE = 1;
    localparam int N      = V * V;

    logic clk;
    logic rst;
    logic busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  rbytes [N-1];
    logic [63:0] last_t;

    ipmult_ctrl_if #(.V(V)) bus ();

    ipmult_ctrl #(
        .V      (V),
        .SETTLE (SETTLE)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // GF(2^8) product: carry-less multiply, then long division by 0x11B
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0000;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--)
            if (p[i]) p = p ^ (16'h011B << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        for (int y = 1; y < 256; y++)
            if (gmul(a, 8'(y)) == 8'h01) return 8'(y);
        return 8'h00;
    endfunction

    // Decode with the last L_hat row as the weight vector
    function automatic logic [7:0] dec(input logic [63:0] x, input logic [N*8-1:0] l);
        logic [7:0] acc;
        acc = 8'h00;
        for (int j = 0; j < V; j++) acc = acc ^ gmul(l[8*((V-1)*V+j) +: 8], x[8*j +: 8]);
        return acc;
    endfunction

    // Reference product T for operands r, q, l and the randomness in rbytes
    function automatic logic [63:0] model_t(input logic [63:0] r, input logic [63:0] q,
                                            input logic [N*8-1:0] l);
        logic [7:0]  p [N];
        logic [7:0]  s;
        logic [7:0]  z;
        logic [7:0]  fix;
        logic [63:0] res;
        s = 8'h00;
        z = 8'h00;
        res = '0;
        for (int k = 0; k < N; k++) begin
            p[k] = gmul(gmul(l[8*k +: 8], r[8*(k/V) +: 8]), q[8*(k%V) +: 8]);
            s    = s ^ p[k];
        end
        for (int k = 0; k < N-1; k++) begin
            p[k] = p[k] ^ rbytes[k];
            z    = z ^ rbytes[k];
        end
        p[N-1] = p[N-1] ^ z;
        fix = s;
        for (int i = 0; i < V-1; i++) begin
            logic [7:0] rs;
            rs = 8'h00;
            for (int j = 0; j < V; j++) rs = rs ^ p[i*V+j];
            res[8*i +: 8] = rs;
            fix = fix ^ gmul(l[8*((V-1)*V+i) +: 8], rs);
        end
        res[8*(V-1) +: 8] = gmul(fix, ginv(l[8*(N-1) +: 8]));
        return res;
    endfunction

    // L_hat(i,j) = w_i*w_j with w_{V-1} = 1
    function automatic logic [N*8-1:0] make_lhat(input logic [63:0] w);
        logic [N*8-1:0] l;
        for (int i = 0; i < V; i++)
            for (int j = 0; j < V; j++)
                l[8*(i*V+j) +: 8] = gmul(w[8*i +: 8], w[8*j +: 8]);
        return l;
    endfunction

    task automatic fill_rand();
        for (int k = 0; k < N-1; k++) rbytes[k] = 8'($urandom);
    endtask

    task automatic check_idle(input string name);
        check($sformatf("%s:in_ready", name),  64'(bus.in_ready),  64'(1));
        check($sformatf("%s:rnd_ready", name), 64'(bus.rnd_ready), 64'(0));
        check($sformatf("%s:out_valid", name), 64'(bus.out_valid), 64'(0));
        check($sformatf("%s:out_err", name),   64'(bus.out_err),   64'(0));
        check($sformatf("%s:busy", name),      64'(busy),          64'(0));
        check($sformatf("%s:out_t", name),     bus.out_t,          64'(0));
    endtask

    // One full operation, starting and ending at a negedge with the DUT idle.
    // rnd_valid is high throughout (except the stall window) so any consumption
    // outside RAND shows up in the byte count.
    task automatic run_op(input string name, input logic [63:0] r, input logic [63:0] q,
                          input logic [N*8-1:0] l, input int stall_len, input int hold);
        logic        err_exp;
        logic [63:0] t_exp;
        logic [63:0] t_seen;
        logic        e_seen;
        logic        stable;
        int          lat_exp;
        int          edges;
        int          taken;
        int          ready_cyc;
        int          stalled;
        int          budget;

        err_exp   = (l[8*(N-1) +: 8] == 8'h00);
        t_exp     = err_exp ? 64'(0) : model_t(r, q, l);
        // Error: out_valid already up at the first sample after the handshake edge
        lat_exp   = err_exp ? 0 : N - 1 + SETTLE + stall_len;
        taken     = 0;
        ready_cyc = 0;
        stalled   = 0;
        budget    = 0;

        bus.in_r      = r;
        bus.in_q      = q;
        bus.in_l_hat  = l;
        bus.in_valid  = 1'b1;
        bus.rnd_valid = 1'b1;
        bus.rnd_data  = rbytes[0];
        bus.out_ready = 1'b0;
        while (!bus.in_ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        check($sformatf("%s:accept", name), 64'(bus.in_ready), 64'(1));
        if (bus.rnd_ready) ready_cyc++;
        if (bus.rnd_ready && bus.rnd_valid) taken++;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        edges = 0;

        while (!bus.out_valid && edges < 400) begin
            bus.rnd_valid = !(taken == 20 && stalled < stall_len);
            if (!bus.rnd_valid) stalled++;
            bus.rnd_data = (taken < N-1) ? rbytes[taken] : 8'hEE;
            if (bus.rnd_ready) ready_cyc++;
            if (bus.rnd_ready && bus.rnd_valid) taken++;
            @(posedge clk);
            @(negedge clk);
            edges++;
        end
        bus.rnd_valid = 1'b1;

        check($sformatf("%s:latency", name),   64'(edges),         64'(lat_exp));
        check($sformatf("%s:out_valid", name), 64'(bus.out_valid), 64'(1));
        check($sformatf("%s:out_t", name),     bus.out_t,          t_exp);
        check($sformatf("%s:out_err", name),   64'(bus.out_err),   64'(err_exp));
        check($sformatf("%s:in_ready_out", name), 64'(bus.in_ready), 64'(0));
        check($sformatf("%s:busy", name),      64'(busy),          64'(1));

        t_seen = bus.out_t;
        e_seen = bus.out_err;
        stable = 1'b1;
        for (int c = 0; c < hold; c++) begin
            if (bus.rnd_ready) ready_cyc++;
            if (bus.rnd_ready && bus.rnd_valid) taken++;
            @(posedge clk);
            @(negedge clk);
            if (!bus.out_valid || bus.out_t !== t_seen || bus.out_err !== e_seen ||
                bus.in_ready || bus.rnd_ready)
                stable = 1'b0;
        end
        if (hold > 0) check($sformatf("%s:hold_stable", name), 64'(stable), 64'(1));

        if (bus.rnd_ready) ready_cyc++;
        if (bus.rnd_ready && bus.rnd_valid) taken++;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.rnd_valid = 1'b0;

        check($sformatf("%s:released_valid", name), 64'(bus.out_valid), 64'(0));
        check($sformatf("%s:released_ready", name), 64'(bus.in_ready),  64'(1));
        check($sformatf("%s:released_busy", name),  64'(busy),          64'(0));
        check($sformatf("%s:rnd_taken", name), 64'(taken), err_exp ? 64'(0) : 64'(N-1));
        check($sformatf("%s:rnd_ready_cycles", name), 64'(ready_cyc),
              err_exp ? 64'(0) : 64'(N - 1 + stall_len));
        last_t = t_seen;
    endtask

    // Start an operation, reset it after 10 random bytes, check the idle state
    task automatic reset_mid_rand();
        int taken;
        int budget;
        taken  = 0;
        budget = 0;
        fill_rand();
        bus.in_r      = {$urandom, $urandom};
        bus.in_q      = {$urandom, $urandom};
        bus.in_l_hat  = {N{8'h01}};
        bus.in_valid  = 1'b1;
        bus.rnd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        while (taken < 10 && budget < 100) begin
            bus.rnd_data = rbytes[taken];
            if (bus.rnd_ready && bus.rnd_valid) taken++;
            @(posedge clk);
            @(negedge clk);
            budget++;
        end
        check("mid_rand:bytes_before_reset", 64'(taken), 64'(10));
        check("mid_rand:busy_before_reset",  64'(busy),  64'(1));
        rst = 1'b1;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b0;
        bus.rnd_valid = 1'b0;
        check_idle("mid_rand_reset");
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0]    r;
        logic [63:0]    q;
        logic [63:0]    w;
        logic [N*8-1:0] l;
        logic [7:0]     pat [3];

        clk           = 1'b0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_r      = '0;
        bus.in_q      = '0;
        bus.in_l_hat  = '0;
        bus.rnd_valid = 1'b0;
        bus.rnd_data  = '0;
        bus.out_ready = 1'b0;
        last_t        = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_idle("reset");

        // All-ones L_hat: T decodes as the plain xor of its shares
        l = {N{8'h01}};
        r = 64'h03;
        q = 64'h02;
        fill_rand();
        run_op("ones_a", r, q, l, 0, 0);
        check("ones_a:decode", 64'(dec(last_t, l)), 64'h06);
        pat[0] = 8'h00;
        pat[1] = 8'hFF;
        pat[2] = 8'h81;
        for (int k = 0; k < N-1; k++) rbytes[k] = pat[k % 3];
        run_op("ones_b", r, q, l, 0, 0);
        check("ones_b:decode", 64'(dec(last_t, l)), 64'h06);

        // Random IPM-shaped operands, alternating randomness stalls and backpressure
        for (int n = 0; n < 6; n++) begin
            w = '0;
            for (int i = 0; i < V-1; i++) w[8*i +: 8] = 8'($urandom_range(1, 255));
            w[8*(V-1) +: 8] = 8'h01;
            l = make_lhat(w);
            r = {$urandom, $urandom};
            q = {$urandom, $urandom};
            fill_rand();
            run_op($sformatf("rand%0d", n), r, q, l, (n % 2 == 1) ? 5 : 0,
                   (n == 0) ? 10 : $urandom_range(0, 6));
            check($sformatf("rand%0d:decode", n), 64'(dec(last_t, l)),
                  64'(gmul(dec(r, l), dec(q, l))));
        end

        // Arbitrary L_hat with a nonzero last byte
        for (int n = 0; n < 2; n++) begin
            for (int k = 0; k < N; k++) l[8*k +: 8] = 8'($urandom);
            l[8*(N-1) +: 8] = 8'($urandom_range(1, 255));
            r = {$urandom, $urandom};
            q = {$urandom, $urandom};
            fill_rand();
            run_op($sformatf("free%0d", n), r, q, l, 5 * n, 2);
        end

        // Singular last L_hat byte
        for (int k = 0; k < N; k++) l[8*k +: 8] = 8'($urandom);
        l[8*(N-1) +: 8] = 8'h00;
        fill_rand();
        run_op("err", {$urandom, $urandom}, {$urandom, $urandom}, l, 0, 10);

        // Reset in the middle of randomness collection, then a clean operation
        reset_mid_rand();
        w = '0;
        for (int i = 0; i < V-1; i++) w[8*i +: 8] = 8'($urandom_range(1, 255));
        w[8*(V-1) +: 8] = 8'h01;
        l = make_lhat(w);
        r = {$urandom, $urandom};
        q = {$urandom, $urandom};
        fill_rand();
        run_op("post_reset", r, q, l, 0, 0);
        check("post_reset:decode", 64'(dec(last_t, l)), 64'(gmul(dec(r, l), dec(q, l))));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/ipmult_ctrl.md
Name: ipmult_ctrl

Overview:
- Sequencing wrapper around the combinational IPM multiplier datapath (IPMult).
- Accepts one operand set (R, Q, L_hat) over a valid/ready handshake.
- Gathers fresh random bytes from a byte-wide randomness stream, registers all datapath inputs, waits a programmable settle time, then presents the registered product T over a valid/ready handshake.
- Sits between the masked-cipher round controller and the shared multiplier instance.

Parameters:
- V, 8, IPM share count; passed to the IPMult instance.
- SETTLE, 1, cycles in COMPUTE before T is captured (≥1; sized for datapath combinational depth).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  operand set valid.
- in_ready  out  1  controller can accept operands.
- in_r  in  V*8  masked operand R, share j in bits [8j+7:8j].
- in_q  in  V*8  masked operand Q.
- in_l_hat  in  V*V*8  L_hat matrix, element (i,j) at [i*8V+8j+7 : i*8V+8j].
- rnd_valid  in  1  random byte valid.
- rnd_ready  out  1  controller consumes random byte.
- rnd_data  in  8  random byte.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_t  out  V*8  registered product T.
- out_err  out  1  qualifies out_valid; set when the last L_hat byte is zero.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (synchronous, any state, including mid-operation):
  - State goes to IDLE.
  - in_ready=1 from the first cycle after reset.
  - rnd_ready=0, out_valid=0, out_err=0, out_t=0, busy=0.
  - Operand, random and counter registers are zeroed; partially collected randomness is discarded.
- States: IDLE, RAND, COMPUTE, OUT.
- IDLE:
  - in_ready=1; all other handshake outputs are 0.
  - On in_valid&in_ready, R, Q and L_hat are captured into registers.
  - If captured L_hat byte (V-1,V-1) == 0: go to OUT with out_t=0, out_err=1. No randomness is consumed.
  - Otherwise: go to RAND with rcnt=0.
- RAND:
  - rnd_ready=1. Each rnd_valid&rnd_ready writes rnd_data into random slot rcnt (bits [8*rcnt+7:8*rcnt] of the rand bus), then rcnt++.
  - The rand bus is V*V*8-1 bits. Only V*V-1 bytes are collected. Bits [V*V*8-2 : (V*V-1)*8] are driven 0 (unused by the datapath).
  - The edge accepting byte V*V-2 moves to COMPUTE with scnt=0.
  - rnd_valid low stalls the state with no timeout.
  - Random bytes offered outside RAND are never consumed (rnd_ready=0).
- COMPUTE:
  - All datapath inputs are held stable from registers; scnt counts cycles.
  - On the edge ending cycle SETTLE-1 of COMPUTE: out_t ← datapath T, out_err=0, go to OUT.
- OUT:
  - out_valid=1. out_t and out_err are held stable until out_ready.
  - On out_valid&out_ready: go to IDLE, out_valid=0.
  - The random register is zeroed on the same edge, so randomness is never reused.
  - in_ready stays 0 during OUT. No overlap or pipelining: one operation in flight.
- Latency with rnd_valid held high: out_valid rises V*V-1+SETTLE edges after the input handshake edge (64 for defaults). Error path: 1 edge.
- Input and output handshakes never complete in the same cycle. in_ready depends only on state (no combinational path from out_ready).
- Counters are sized ceil(log2(V*V)) and ceil(log2(SETTLE+1)). No wrap: rcnt is cleared on entering RAND.

Test Plan:
- Reset/idle: assert rst 3 cycles, in mid-RAND after 10 bytes → next cycle in_ready=1, rnd_ready=0, out_valid=0, busy=0, out_t=0. A following operation consumes a full fresh V*V-1 bytes.
- Functional, V=2:
  - Stimulus: L_hat all bytes 0x01, R=(0x03,0x00), Q=(0x02,0x00), rnd bytes 0x5A,0xC3,0x17.
  - Expected: out_t[7:0]^out_t[15:8]==0x06, out_err=0.
  - Repeat with random bytes 0x00,0xFF,0x81: the same decoded 0x06, with different shares.
- Latency, V=8, SETTLE=1, rnd_valid constant: out_valid rises exactly 64 edges after the in handshake. rnd_ready is high for exactly 63 cycles.
- Randomness stall: drop rnd_valid for 5 cycles after byte 20 → latency increases by exactly 5. Byte order in the rand bus matches arrival order (compare against the golden model).
- Output backpressure: hold out_ready=0 for 10 cycles → out_valid, out_t and out_err stay constant; in_ready=0 and rnd_ready=0 throughout. Release → IDLE next cycle.
- Error path: L_hat byte (V-1,V-1)=0x00 → out_valid one edge after the handshake, out_err=1, out_t=0, zero random bytes consumed.
